// File: rtl/bulk_in_arb.sv
// bulk_in_arb: round-robin packet-burst arbiter in front of the bulk IN
// endpoint. N_REQ byte-stream requesters share one app-side IN interface.
// Each grant lasts up to BURST_LEN transferred bytes. The grant ends early
// when the granted requester drops valid.
// Optional feature, macro BULK_IN_ARB_TAG_EN: each grant first emits one tag
// byte (TAG_BASE | granted index). The tag byte is not counted in the burst.
module bulk_in_arb #(
   parameter int         N_REQ     = 2,
   parameter int         BURST_LEN = 8,
   parameter logic [7:0] TAG_BASE  = 8'hA0
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [8*N_REQ-1:0]   req_data_i,
   input  logic [N_REQ-1:0]     req_valid_i,
   output logic [N_REQ-1:0]     req_ready_o,
   output logic [7:0]           app_in_data_o,
   output logic                 app_in_valid_o,
   input  logic                 app_in_ready_i,
   output logic [N_REQ-1:0]     grant_o,
   output logic                 busy_o
);

   localparam int         IW       = (N_REQ > 2) ? 2 : 1;
   localparam logic [6:0] LAST_CNT = 7'(BURST_LEN - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1
`ifdef BULK_IN_ARB_TAG_EN
      , S_TAG = 2'd2
`endif
   } state_t;

   state_t          r_state;
   logic [IW-1:0]   r_idx;
   logic [IW-1:0]   r_last;
   logic [6:0]      r_cnt;
   logic [N_REQ-1:0] r_grant;
   logic            r_busy;

   logic [7:0]       w_bytes [N_REQ];
   logic [IW-1:0]    w_pick;
   logic [N_REQ-1:0] w_pick_oh;
   logic             w_found;
   logic             w_gvalid;

   // Unpack the flat data bus into one byte per requester.
   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign w_bytes[gi] = req_data_i[8*gi +: 8];
      end
   endgenerate

   assign w_gvalid = req_valid_i[r_idx];

   // Round-robin pick: first valid requester after the last served one.
   // The wrap is an explicit modulo-N_REQ subtract, so N_REQ=3 works.
   always_comb begin
      logic [IW:0] c;
      w_pick    = r_last;
      w_found   = 1'b0;
      w_pick_oh = '0;
      c         = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         c = {1'b0, r_last} + (IW+1)'(i);
         if (c >= (IW+1)'(N_REQ)) begin
            c = c - (IW+1)'(N_REQ);
         end
         if (!w_found && req_valid_i[c[IW-1:0]]) begin
            w_found = 1'b1;
            w_pick  = c[IW-1:0];
         end
      end
      w_pick_oh[w_pick] = 1'b1;
   end

   // Output steering: data and valid pass straight through from the
   // granted requester. Only the granted requester sees app ready.
   always_comb begin
      app_in_data_o  = 8'h00;
      app_in_valid_o = 1'b0;
      req_ready_o    = '0;
      case (r_state)
         S_GRANT: begin
            app_in_data_o  = w_bytes[r_idx];
            app_in_valid_o = w_gvalid;
            req_ready_o    = app_in_ready_i ? r_grant : '0;
         end
`ifdef BULK_IN_ARB_TAG_EN
         S_TAG: begin
            app_in_data_o  = TAG_BASE | 8'(r_idx);
            app_in_valid_o = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // Grant FSM: arbitrate in IDLE, count transferred bytes in GRANT.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_last  <= LAST_IDX;
         r_cnt   <= '0;
         r_grant <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_idx   <= w_pick;
                  r_last  <= w_pick;
                  r_grant <= w_pick_oh;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
`ifdef BULK_IN_ARB_TAG_EN
                  r_state <= S_TAG;
`else
                  r_state <= S_GRANT;
`endif
               end
            end
`ifdef BULK_IN_ARB_TAG_EN
            S_TAG: begin
               if (app_in_ready_i) begin
                  r_state <= S_GRANT;
               end
            end
`endif
            S_GRANT: begin
               if (!w_gvalid) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_grant <= '0;
                  r_busy  <= 1'b0;
               end else if (app_in_ready_i) begin
                  if (r_cnt == LAST_CNT) begin
                     r_state <= S_IDLE;
                     r_cnt   <= '0;
                     r_grant <= '0;
                     r_busy  <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + 7'd1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_grant <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign grant_o = r_grant;
   assign busy_o  = r_busy;

endmodule

// File: tb/tb_bulk_in_arb.sv
// Testbench for bulk_in_arb. The bench drives two instances: N_REQ=2 for
// the main checks and N_REQ=3 for the wrap check. A requester-level
// reference model predicts the outputs cycle by cycle and logs the
// transferred bytes.
module tb_bulk_in_arb;

   localparam int BURST = 8;
`ifdef BULK_IN_ARB_TAG_EN
   localparam int TAGC = 1;
`else
   localparam int TAGC = 0;
`endif

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic [15:0] d2;
   logic [1:0]  v2, r2o, g2;
   logic [7:0]  ad2;
   logic        av2, ar2, b2;
   logic [23:0] d3;
   logic [2:0]  v3, r3o, g3;
   logic [7:0]  ad3;
   logic        av3, ar3, b3;

   bulk_in_arb #(.N_REQ(2), .BURST_LEN(BURST), .TAG_BASE(8'hA0)) dut2 (
      .clk_i(clk), .rstn_i(rstn), .req_data_i(d2), .req_valid_i(v2),
      .req_ready_o(r2o), .app_in_data_o(ad2), .app_in_valid_o(av2),
      .app_in_ready_i(ar2), .grant_o(g2), .busy_o(b2));

   bulk_in_arb #(.N_REQ(3), .BURST_LEN(BURST), .TAG_BASE(8'hA0)) dut3 (
      .clk_i(clk), .rstn_i(rstn), .req_data_i(d3), .req_valid_i(v3),
      .req_ready_o(r3o), .app_in_data_o(ad3), .app_in_valid_o(av3),
      .app_in_ready_i(ar3), .grant_o(g3), .busy_o(b3));

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: current owner (-1 = nobody), bytes sent, last served.
   int m_owner, m_cnt, m_last;
   bit m_tag;
   // Sources: bytes remaining, current byte, enable, increment per byte.
   int         src_rem  [2];
   logic [7:0] src_byte [2];
   bit         src_en   [2];
   logic [7:0] src_step [2];
   // Scoreboard entries are {is_tag, source, byte}.
   logic [9:0] out_q[$];
   int         glog[$];

   task automatic model_reset();
      m_owner = -1; m_cnt = 0; m_last = 1; m_tag = 1'b0;
      out_q.delete(); glog.delete();
   endtask

   task automatic drive2();
      v2 = {(src_rem[1] > 0) && src_en[1], (src_rem[0] > 0) && src_en[0]};
      d2 = {src_byte[1], src_byte[0]};
   endtask

   function automatic logic [13:0] model_expect();
      logic [1:0] g;
      logic       vo;
      logic [7:0] bo;
      if (m_owner < 0) return 14'h0;
      g  = 2'b01 << m_owner;
      vo = (m_owner == 0) ? v2[0] : v2[1];
      bo = (m_owner == 0) ? d2[7:0] : d2[15:8];
      if (m_tag) return {g, 1'b1, 1'b1, 8'hA0 | 8'(m_owner), 2'b00};
      return {g, 1'b1, vo, bo, ar2 ? g : 2'b00};
   endfunction

   task automatic model_step();
      logic       vo;
      logic [7:0] bo;
      int         c;
      vo = (m_owner == 1) ? v2[1] : v2[0];
      bo = (m_owner == 1) ? d2[15:8] : d2[7:0];
      if (m_owner < 0) begin
         for (int i = 1; i <= 2; i++) begin
            c = (m_last + i) % 2;
            if (m_owner < 0 && v2[c[0]]) begin
               m_owner = c; m_last = c; m_cnt = 0; m_tag = (TAGC != 0);
               glog.push_back(c);
            end
         end
      end else if (m_tag) begin
         if (ar2) begin
            out_q.push_back({1'b1, m_owner[0], 8'hA0 | 8'(m_owner)});
            m_tag = 1'b0;
         end
      end else if (!vo) begin
         m_owner = -1;
      end else if (ar2) begin
         out_q.push_back({1'b0, m_owner[0], bo});
         m_cnt++;
         if (m_cnt == BURST) m_owner = -1;
      end
      // sources follow the handshake they see on their own port
      if (v2[0] && r2o[0]) begin src_rem[0]--; src_byte[0] += src_step[0]; end
      if (v2[1] && r2o[1]) begin src_rem[1]--; src_byte[1] += src_step[1]; end
   endtask

   function automatic bq_t data_bytes();
      bq_t q;
      foreach (out_q[i]) if (!out_q[i][9]) q.push_back(out_q[i][7:0]);
      return q;
   endfunction

   task automatic do_reset();
      rstn = 1'b0;
      v2 = '0; d2 = '0; ar2 = 1'b0; v3 = '0; d3 = '0; ar3 = 1'b0;
      src_rem = '{0, 0}; src_en = '{1, 1}; src_step = '{8'd1, 8'd1};
      src_byte = '{8'h00, 8'h00};
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      v2 = 2'b11; d2 = 16'hFFFF; ar2 = 1'b1;
      v3 = 3'b111; d3 = '1; ar3 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({g2, b2, av2, ad2, r2o} !== 14'h0) begin
         n_fail++;
         $display("FAIL reset_n2 got %h want 0", {g2, b2, av2, ad2, r2o});
      end
      n_tests++;
      if ({g3, b3, av3, ad3, r3o} !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_n3 got %h want 0", {g3, b3, av3, ad3, r3o});
      end
      $display("[TB] reset checked");
      do_reset();
   endtask

   task automatic test_single_burst();
      logic [13:0] exp;
      bq_t q;
      bit ok;
      do_reset();
      src_rem[0] = 20; src_byte[0] = 8'h00; ar2 = 1'b1;
      for (int c = 0; c < 30; c++) begin
         drive2(); @(negedge clk);
         exp = model_expect(); n_tests++;
         if ({g2, b2, av2, ad2, r2o} !== exp) begin
            n_fail++;
            $display("FAIL single cyc %0d got %h want %h", c, {g2, b2, av2, ad2, r2o}, exp);
         end
         model_step(); @(posedge clk); #1;
      end
      q = data_bytes(); ok = (q.size() == 20);
      foreach (q[i]) if (q[i] != 8'(i)) ok = 1'b0;
      n_tests++;
      if (!ok || glog.size() != 3) begin
         n_fail++;
         $display("FAIL single_stream got %0d bytes %0d grants want 20 bytes 3 grants", q.size(), glog.size());
      end
      $display("[TB] single burst: %0d bytes in %0d grants", q.size(), glog.size());
   endtask

   task automatic test_round_robin();
      logic [13:0] exp;
      do_reset();
      src_rem = '{1000, 1000}; src_byte = '{8'h00, 8'h80}; ar2 = 1'b1;
      for (int c = 0; c < 1 + 4 * (BURST + 1 + TAGC); c++) begin
         drive2(); @(negedge clk);
         exp = model_expect(); n_tests++;
         if ({g2, b2, av2, ad2, r2o} !== exp) begin
            n_fail++;
            $display("FAIL rr cyc %0d got %h want %h", c, {g2, b2, av2, ad2, r2o}, exp);
         end
         model_step(); @(posedge clk); #1;
      end
      n_tests++;
      if (glog.size() < 4 || glog[0] != 0 || glog[1] != 1 || glog[2] != 0 || glog[3] != 1) begin
         n_fail++;
         $display("FAIL rr_order got %p want 0,1,0,1", glog);
      end
      $display("[TB] round robin: %0d grants", glog.size());
   endtask

   task automatic test_rr3();
      int p, xfer;
      logic [2:0] expg;
      localparam int P = BURST + 1 + TAGC;
      do_reset();
      v3 = 3'b111; ar3 = 1'b1; xfer = 0;
      for (int c = 0; c < 1 + 4 * P; c++) begin
         d3 = 24'($urandom);
         @(negedge clk);
         if (c == 0) expg = 3'b000;
         else begin
            p = (c - 1) % P;
            expg = (p < BURST + TAGC) ? (3'b001 << (((c - 1) / P) % 3)) : 3'b000;
         end
         n_tests++;
         if (g3 !== expg) begin
            n_fail++;
            $display("FAIL rr3 cyc %0d got %b want %b", c, g3, expg);
         end
         if (av3 && ar3) xfer++;
         @(posedge clk); #1;
      end
      n_tests++;
      if (xfer != 4 * (BURST + TAGC)) begin
         n_fail++;
         $display("FAIL rr3_count got %0d want %0d", xfer, 4 * (BURST + TAGC));
      end
      v3 = '0; ar3 = 1'b0;
      $display("[TB] rr3: %0d transfers", xfer);
   endtask

   task automatic test_backpressure();
      logic [13:0] exp;
      bq_t q;
      bit ok;
      do_reset();
      src_rem[1] = 8; src_byte[1] = 8'h40;
      for (int c = 0; c < 30; c++) begin
         ar2 = c[0];
         drive2(); @(negedge clk);
         exp = model_expect(); n_tests++;
         if ({g2, b2, av2, ad2, r2o} !== exp) begin
            n_fail++;
            $display("FAIL bp cyc %0d got %h want %h", c, {g2, b2, av2, ad2, r2o}, exp);
         end
         model_step(); @(posedge clk); #1;
      end
      q = data_bytes(); ok = (q.size() == 8);
      foreach (q[i]) if (q[i] != 8'h40 + 8'(i)) ok = 1'b0;
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL bp_stream got %p want 40..47", q);
      end
      $display("[TB] backpressure: %0d bytes", q.size());
   endtask

   task automatic test_early_release();
      logic [13:0] exp;
      bq_t q;
      do_reset();
      src_rem = '{1000, 1000}; src_byte = '{8'h10, 8'h90}; ar2 = 1'b1;
      for (int c = 0; c < 16; c++) begin
         src_en[0] = (src_byte[0] < 8'h13);
         drive2(); @(negedge clk);
         exp = model_expect(); n_tests++;
         if ({g2, b2, av2, ad2, r2o} !== exp) begin
            n_fail++;
            $display("FAIL early cyc %0d got %h want %h", c, {g2, b2, av2, ad2, r2o}, exp);
         end
         model_step(); @(posedge clk); #1;
      end
      q = data_bytes();
      n_tests++;
      if (q.size() < 4 || q[2] != 8'h12 || q[3] != 8'h90 || glog.size() < 2 || glog[1] != 1) begin
         n_fail++;
         $display("FAIL early_seq got %p want 10,11,12,90..", q);
      end
      $display("[TB] early release: %0d bytes", q.size());
   endtask

   task automatic test_reset_midburst();
      logic [13:0] exp;
      bq_t q;
      do_reset();
      src_rem[0] = 10; src_byte[0] = 8'h20; ar2 = 1'b1;
      for (int c = 0; c < 4 + TAGC; c++) begin
         drive2(); @(negedge clk);
         exp = model_expect(); n_tests++;
         if ({g2, b2, av2, ad2, r2o} !== exp) begin
            n_fail++;
            $display("FAIL midrst cyc %0d got %h want %h", c, {g2, b2, av2, ad2, r2o}, exp);
         end
         model_step(); @(posedge clk); #1;
      end
      drive2();
      #2 rstn = 1'b0;
      #1 n_tests++;
      if ({g2, b2, av2, r2o} !== 6'h0) begin
         n_fail++;
         $display("FAIL midrst_async got %h want 0", {g2, b2, av2, r2o});
      end
      @(posedge clk); #1 rstn = 1'b1;
      model_reset();
      for (int c = 0; c < 6; c++) begin
         drive2(); @(negedge clk);
         exp = model_expect(); n_tests++;
         if ({g2, b2, av2, ad2, r2o} !== exp) begin
            n_fail++;
            $display("FAIL midrst_after cyc %0d got %h want %h", c, {g2, b2, av2, ad2, r2o}, exp);
         end
         model_step(); @(posedge clk); #1;
      end
      q = data_bytes();
      n_tests++;
      if (q.size() < 1 || q[0] != 8'h23) begin
         n_fail++;
         $display("FAIL midrst_resume got %p want 23..", q);
      end
      $display("[TB] reset mid-burst: resumed with %0d bytes", q.size());
   endtask

   task automatic test_random();
      logic [13:0] exp;
      logic [7:0] nxt [2];
      int bad;
      do_reset();
      src_rem = '{1000, 1000};
      src_byte = '{8'($urandom), 8'($urandom)};
      nxt = src_byte;
      for (int c = 0; c < 400; c++) begin
         src_en[0] = ($urandom_range(0, 9) != 0);
         src_en[1] = ($urandom_range(0, 9) != 0);
         ar2 = ($urandom_range(0, 3) != 0);
         drive2(); @(negedge clk);
         exp = model_expect(); n_tests++;
         if ({g2, b2, av2, ad2, r2o} !== exp) begin
            n_fail++;
            $display("FAIL rand cyc %0d got %h want %h", c, {g2, b2, av2, ad2, r2o}, exp);
         end
         model_step(); @(posedge clk); #1;
      end
      bad = 0;
      foreach (out_q[i]) if (!out_q[i][9]) begin
         if (out_q[i][7:0] != nxt[out_q[i][8]]) bad++;
         nxt[out_q[i][8]] = out_q[i][7:0] + 8'd1;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL rand_order got %0d out-of-order bytes want 0", bad);
      end
      $display("[TB] random: %0d bytes, %0d grants", out_q.size(), glog.size());
   endtask

`ifdef BULK_IN_ARB_TAG_EN
   task automatic test_tag();
      logic [13:0] exp;
      do_reset();
      src_rem[1] = 3; src_byte[1] = 8'h55; src_step[1] = 8'd0; ar2 = 1'b1;
      for (int c = 0; c < 8; c++) begin
         drive2(); @(negedge clk);
         exp = model_expect(); n_tests++;
         if ({g2, b2, av2, ad2, r2o} !== exp) begin
            n_fail++;
            $display("FAIL tag cyc %0d got %h want %h", c, {g2, b2, av2, ad2, r2o}, exp);
         end
         model_step(); @(posedge clk); #1;
      end
      n_tests++;
      if (out_q.size() != 4 || out_q[0][7:0] != 8'hA1 || out_q[1][7:0] != 8'h55 ||
          out_q[3][7:0] != 8'h55) begin
         n_fail++;
         $display("FAIL tag_seq got %p want A1,55,55,55", out_q);
      end
      // reset while the tag byte is stalled
      do_reset();
      src_rem[0] = 2; src_byte[0] = 8'h33; ar2 = 1'b0;
      for (int c = 0; c < 2; c++) begin
         drive2(); @(negedge clk);
         exp = model_expect(); n_tests++;
         if ({g2, b2, av2, ad2, r2o} !== exp) begin
            n_fail++;
            $display("FAIL tagrst cyc %0d got %h want %h", c, {g2, b2, av2, ad2, r2o}, exp);
         end
         if (c == 0) begin model_step(); @(posedge clk); #1; end
      end
      rstn = 1'b0;
      #1 n_tests++;
      if ({g2, b2, av2, r2o} !== 6'h0) begin
         n_fail++;
         $display("FAIL tagrst_async got %h want 0", {g2, b2, av2, r2o});
      end
      @(posedge clk); #1 rstn = 1'b1;
      model_reset(); ar2 = 1'b1;
      for (int c = 0; c < 6; c++) begin
         drive2(); @(negedge clk);
         exp = model_expect(); n_tests++;
         if ({g2, b2, av2, ad2, r2o} !== exp) begin
            n_fail++;
            $display("FAIL tagrst_after cyc %0d got %h want %h", c, {g2, b2, av2, ad2, r2o}, exp);
         end
         model_step(); @(posedge clk); #1;
      end
      $display("[TB] tag: %0d entries after reset", out_q.size());
   endtask
`endif

   initial begin
      rstn = 1'b0;
      test_reset();
      test_single_burst();
      test_round_robin();
      test_rr3();
      test_backpressure();
      test_early_release();
      test_reset_midburst();
      test_random();
`ifdef BULK_IN_ARB_TAG_EN
      test_tag();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bulk_in_arb.md
Name: bulk_in_arb

Overview:
- Packet-burst arbiter that shares the single app-side IN interface of the bulk endpoint (app_in_data/valid/ready) among N_REQ byte-stream requesters.
- Sits in the clk_i domain, between the application sources and the bulk endpoint's IN FIFO.
- Grants one requester at a time, round-robin, for a burst of up to BURST_LEN bytes, so no source can starve the others.

Parameters:
- N_REQ, 2, number of requesters; legal range 2..4.
- BURST_LEN, 8, maximum bytes per grant; legal range 1..64; normally set equal to IN_BULK_MAXPACKETSIZE.
- TAG_BASE, 8'hA0, tag byte base; used only with the optional feature; low 2 bits must be 0.

Ports:
- clk_i  in  1  clock; same domain as the bulk endpoint app interface.
- rstn_i  in  1  asynchronous, active-low reset.
- req_data_i  in  8*N_REQ  byte of requester k on bits [8k+7:8k].
- req_valid_i  in  N_REQ  requester k has a byte.
- req_ready_o  out  N_REQ  byte of requester k consumed when valid and ready are both high.
- app_in_data_o  out  8  to bulk endpoint app_in_data_i.
- app_in_valid_o  out  1  to bulk endpoint app_in_valid_i.
- app_in_ready_i  in  1  from bulk endpoint app_in_ready_o.
- grant_o  out  N_REQ  one-hot current grant; all zero when idle.
- busy_o  out  1  high while a grant is active (state is not IDLE).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, grant_o=0, busy_o=0, app_in_valid_o=0, req_ready_o=0, app_in_data_o=0.
  - Byte counter=0; last-grant pointer=N_REQ-1, so requester 0 has first priority.
- States: IDLE, GRANT; TAG exists only with the optional feature.
- IDLE:
  - Outputs are quiet: valid=0, all readies=0, data=0.
  - If any req_valid_i bit is high, select the first valid index searching from last+1 upward, wrapping modulo N_REQ.
  - Register that index into grant and pointer; next state is GRANT.
  - Arbitration latency is exactly 1 cycle from valid to grant.
- GRANT (granted index g):
  - app_in_data_o = req_data_i[g], app_in_valid_o = req_valid_i[g]; combinational pass-through.
  - req_ready_o[g] = app_in_ready_i; all other readies = 0.
  - A transfer is app_in_valid_o & app_in_ready_i; the counter increments on each transfer.
  - A transfer with counter == BURST_LEN-1 ends the burst: next state IDLE, counter cleared, grant cleared.
  - req_valid_i[g] low in any GRANT cycle also ends the burst immediately (no transfer in that cycle): next state IDLE, counter cleared.
  - app_in_ready_i low with valid high: hold the state and counter; no timeout.
- Fairness: the served requester has lowest priority at the next arbitration.
  - Two continuously valid requesters alternate bursts.
  - A single continuously valid requester gets BURST_LEN-byte bursts separated by exactly 1 IDLE cycle.
- Width rules:
  - Counter is 7 bits (covers BURST_LEN max 64) and never exceeds BURST_LEN-1.
  - Pointer increment wraps modulo N_REQ; it is not a power-of-2 wrap when N_REQ=3.
- A requester raising valid while another holds the grant waits; there is no preemption.
- Reset mid-burst: state returns to IDLE immediately and all readies drop asynchronously.
  - Any byte in flight is not consumed.

Optional Feature:
- Macro: BULK_IN_ARB_TAG_EN.
- Defined:
  - On grant, IDLE goes to TAG, not GRANT.
  - TAG drives app_in_data_o = TAG_BASE | g and app_in_valid_o = 1, with all req_ready_o = 0.
  - TAG holds until app_in_ready_i is high, then moves to GRANT.
  - The tag byte is not counted toward BURST_LEN. Reset during TAG returns to IDLE.
  - If req_valid_i[g] drops during TAG, the tag is still completed, then GRANT ends immediately.
- Undefined: TAG state and its logic are absent; IDLE goes directly to GRANT.

Test Plan:
- Reset: hold rstn_i=0 with all inputs active -> grant_o=0, app_in_valid_o=0, busy_o=0, req_ready_o=0.
- Single requester burst: req0 streams bytes 0x00..0x13 continuously, ready=1, BURST_LEN=8.
  - Output 0x00-0x07, 1 idle cycle, 0x08-0x0F, 1 idle cycle, 0x10-0x13.
  - Grant ends when req0 valid drops.
- Round-robin: req0 and req1 both continuously valid, N_REQ=2.
  - Grant sequence is 0,1,0,1, with 8 bytes each; first grant 1 cycle after valid.
  - N_REQ=3 with all three valid -> 0,1,2,0 (wrap check).
- Backpressure: toggle app_in_ready_i 1/0 every cycle during req1's burst.
  - Exactly 8 bytes transferred, in order; counter holds while ready=0; no byte duplicated or lost.
- Early release: req0 drops valid after 3 bytes while req1 is valid.
  - Burst ends; 1 cycle later grant_o=2'b10 and req1 data appears.
- Tag feature (BULK_IN_ARB_TAG_EN defined): req1 sends 0x55 x3.
  - Output 0xA1, 0x55, 0x55, 0x55; req_ready_o[1] stays low during the tag cycle.
  - Assert reset during TAG -> IDLE, no data consumed.
